// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and FSM state encoding for the data-memory responder.
// Provides default bus widths, the wait-counter width and the IDLE/WAIT/RESP states.
// The state values are plain localparams so older code can keep using them directly.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  // Wide enough for the largest legal wait-state count (15).
  localparam int CNT_W      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage with one synchronous write port and one registered read port.
// Latency: write lands on the enabled edge; read data appears after the enabled edge.
// Backpressure: none; the caller pulses wr_en_i / rd_en_i once per committed access.
// Ports: clk_i, rst_i (clears only the read register), wr_en_i, rd_en_i, addr_i, wr_dat_i, rd_dat_o.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  // Storage is deliberately not reset: contents are undefined until written.
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_dat_i;
    end
  end

  // The read register does reset, so the CPU sees 0 on load data after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store responder for the 8-bit CPU, owning a DEPTH x DATA_W array.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the request is accepted in IDLE.
// Backpressure: requests while busy are dropped, not queued; CPU re-asserts req after ready.
// Ports: clk, reset (async, active-high), req/MW/Address/Data_in (sampled in IDLE only),
//        Data_out (last read), ready (1-cycle), busy; rd_count/wr_count only with DMEM_STATS_EN.
// Optional feature macro: DMEM_STATS_EN adds 16-bit wrapping read/write completion counters.
// DEPTH must equal 2**ADDR_W; there is no address wrap or range check.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              MW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              ready,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mw_q, mw_d;
  logic              commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mw_d    = mw_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = Address;
          data_d = Data_in;
          mw_d   = MW;
          cnt_d  = WAIT_LD;
          if (WAIT_LD == '0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Leave on the edge where the counter reaches zero.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mw_q    <= mw_d;
    end
  end

  // The array is fed from the next-state hold values: with zero wait states
  // the commit edge is the same edge that captures the request.
  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (commit & mw_d),
    .rd_en_i  (commit & ~mw_d),
    .addr_i   (addr_d),
    .wr_dat_i (data_d),
    .rd_dat_o (Data_out)
  );

  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      if (mw_d) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WA = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, mw_a, ready_a, busy_a;
  logic [7:0] addr_a, din_a, dout_a;
  logic       req_b, mw_b, ready_b, busy_b;
  logic [7:0] addr_b, din_b, dout_b;
`ifdef DMEM_STATS_EN
  logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Access-level reference model for instance A.
  logic [7:0] ref_mem [0:255];
  bit         ref_vld [0:255];
  logic [7:0] exp_dout;
  bit         dout_known;
  int         exp_rd, exp_wr;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(WA)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .req      (req_a),
    .MW       (mw_a),
    .Address  (addr_a),
    .Data_in  (din_a),
    .Data_out (dout_a),
    .ready    (ready_a),
    .busy     (busy_a)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rdc_a),
    .wr_count (wrc_a)
`endif
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .req      (req_b),
    .MW       (mw_b),
    .Address  (addr_b),
    .Data_in  (din_b),
    .Data_out (dout_b),
    .ready    (ready_b),
    .busy     (busy_b)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rdc_b),
    .wr_count (wrc_b)
`endif
  );

  // One full access on instance A; checks latency, busy length, Data_out and the idle cycle after.
  task automatic access_a(input logic mw, input logic [7:0] a, input logic [7:0] d);
    int lat;
    int bcyc;
    bit got;
    @(negedge clk);
    req_a = 1'b1; mw_a = mw; addr_a = a; din_a = d;
    @(negedge clk);
    // Garbage on the bus after the request cycle must not matter.
    req_a = 1'b0; mw_a = 1'($urandom); addr_a = 8'($urandom); din_a = 8'($urandom);
    lat = 0; bcyc = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      lat++;
      if (busy_a === 1'b1) bcyc++;
      if (ready_a === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (mw) begin
      ref_mem[a] = d; ref_vld[a] = 1'b1; exp_wr++;
    end else begin
      exp_rd++;
      if (ref_vld[a]) begin exp_dout = ref_mem[a]; dout_known = 1'b1; end
      else dout_known = 1'b0;
    end
    n_vec++;
    if (!got || lat != WA + 1) begin
      n_err++; $display("FAIL latency a=%02h mw=%0b: got %0d (ready seen=%0b), want %0d", a, mw, lat, got, WA + 1);
    end
    n_vec++;
    if (bcyc != WA + 1) begin
      n_err++; $display("FAIL busy_len a=%02h: got %0d, want %0d", a, bcyc, WA + 1);
    end
    if (dout_known) begin
      n_vec++;
      if (dout_a !== exp_dout) begin
        n_err++; $display("FAIL dout a=%02h mw=%0b: got %02h, want %02h", a, mw, dout_a, exp_dout);
      end
    end
`ifdef DMEM_STATS_EN
    n_vec++;
    if (rdc_a !== 16'(exp_rd) || wrc_a !== 16'(exp_wr)) begin
      n_err++; $display("FAIL stats: got rd=%0d wr=%0d, want rd=%0d wr=%0d", rdc_a, wrc_a, 16'(exp_rd), 16'(exp_wr));
    end
`endif
    @(negedge clk);
    n_vec++;
    if (ready_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL idle_after a=%02h: got ready=%b busy=%b, want 0 0", a, ready_a, busy_a);
    end
    if (dout_known) begin
      n_vec++;
      if (dout_a !== exp_dout) begin
        n_err++; $display("FAIL dout_hold a=%02h: got %02h, want %02h", a, dout_a, exp_dout);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = 1'b0; mw_a = 1'b0; addr_a = '0; din_a = '0;
    req_b = 1'b0; mw_b = 1'b0; addr_b = '0; din_b = '0;
    exp_dout = 8'h00; dout_known = 1'b1; exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ready_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 8'h00) begin
      n_err++; $display("FAIL reset_a: got ready=%b busy=%b dout=%02h, want 0 0 00", ready_a, busy_a, dout_a);
    end
    n_vec++;
    if (ready_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 8'h00) begin
      n_err++; $display("FAIL reset_b: got ready=%b busy=%b dout=%02h, want 0 0 00", ready_b, busy_b, dout_b);
    end
`ifdef DMEM_STATS_EN
    n_vec++;
    if (rdc_a !== 16'h0 || wrc_a !== 16'h0) begin
      n_err++; $display("FAIL reset_stats: got rd=%0d wr=%0d, want 0 0", rdc_a, wrc_a);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    access_a(1'b1, 8'h3C, 8'hA5);
    access_a(1'b0, 8'h3C, 8'h00);
    n_vec++;
    if (dout_a !== 8'hA5) begin
      n_err++; $display("FAIL write_read: got %02h, want a5", dout_a);
    end
  endtask

  task automatic test_dout_hold();
    access_a(1'b1, 8'h55, 8'h42);
    access_a(1'b0, 8'h55, 8'h00);
    access_a(1'b1, 8'h20, 8'h77);
    n_vec++;
    if (dout_a !== 8'h42) begin
      n_err++; $display("FAIL write_keeps_dout: got %02h, want 42", dout_a);
    end
    access_a(1'b0, 8'h20, 8'h00);
    n_vec++;
    if (dout_a !== 8'h77) begin
      n_err++; $display("FAIL read_new_data: got %02h, want 77", dout_a);
    end
  endtask

  // req held high with Address changing every cycle: only IDLE-cycle addresses are accessed.
  task automatic test_req_hold();
    logic [7:0] seq [0:31];
    bit exp_rdy, exp_bsy;
    logic [7:0] want;
    for (int i = 0; i < 8; i++) access_a(1'b1, 8'h80 + 8'(i), 8'h10 * 8'(i) + 8'h09);
    seq[0] = 8'h80 + 8'($urandom_range(0, 7));
    for (int k = 1; k < 32; k++) seq[k] = seq[0] ^ 8'($urandom_range(1, 7));
    for (int k = 0; k <= 2 * WA + 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_rdy = (k == WA + 1) || (k == 2 * WA + 3);
        exp_bsy = (k >= 1 && k <= WA + 1) || (k >= WA + 3 && k <= 2 * WA + 3);
        n_vec++;
        if (ready_a !== exp_rdy || busy_a !== exp_bsy) begin
          n_err++; $display("FAIL req_hold_cycle%0d: got ready=%b busy=%b, want %b %b", k, ready_a, busy_a, exp_rdy, exp_bsy);
        end
        if (exp_rdy) begin
          want = ref_mem[(k == WA + 1) ? seq[0] : seq[WA + 2]];
          n_vec++;
          if (dout_a !== want) begin
            n_err++; $display("FAIL req_hold_data cycle%0d: got %02h, want %02h", k, dout_a, want);
          end
          exp_dout = want; dout_known = 1'b1; exp_rd++;
        end
      end
      if (k < 2 * WA + 3) begin
        req_a = 1'b1; mw_a = 1'b0; addr_a = seq[k]; din_a = 8'($urandom);
      end else begin
        req_a = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++; $display("FAIL req_hold_end: got busy=%b, want 0", busy_a);
    end
  endtask

  // Reset during the wait states of a write: nothing is committed and no ready appears.
  task automatic test_reset_mid();
    bit saw_rdy;
    access_a(1'b1, 8'h10, 8'h33);
    @(negedge clk);
    req_a = 1'b1; mw_a = 1'b1; addr_a = 8'h10; din_a = 8'h5A;
    @(negedge clk);
    req_a = 1'b0;
    n_vec++;
    if (busy_a !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_pre: got busy=%b, want 1", busy_a);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (ready_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_now: got ready=%b busy=%b dout=%02h, want 0 0 00", ready_a, busy_a, dout_a);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_dout = 8'h00; dout_known = 1'b1; exp_rd = 0; exp_wr = 0;
    saw_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready_a === 1'b1) saw_rdy = 1'b1;
    end
    n_vec++;
    if (saw_rdy) begin
      n_err++; $display("FAIL reset_mid_ready: got ready pulse, want none");
    end
    access_a(1'b0, 8'h10, 8'h00);
    n_vec++;
    if (dout_a !== 8'h33) begin
      n_err++; $display("FAIL reset_mid_dropped: got %02h, want 33", dout_a);
    end
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    access_a(1'b0, 8'h3C, 8'h00);
    access_a(1'b1, 8'h01, 8'h5E);
    access_a(1'b0, 8'h01, 8'h00);
    access_a(1'b1, 8'h02, 8'h6F);
    n_vec++;
    if (rdc_a !== 16'd3 || wrc_a !== 16'd2) begin
      n_err++; $display("FAIL stats_3_2: got rd=%0d wr=%0d, want 3 2", rdc_a, wrc_a);
    end
    @(negedge clk);
    force dut_a.wr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.wr_cnt_q;
    exp_wr = 16'hFFFF;
    access_a(1'b1, 8'h03, 8'h7A);
    n_vec++;
    if (wrc_a !== 16'h0000) begin
      n_err++; $display("FAIL stats_wrap: got wr=%04h, want 0000", wrc_a);
    end
    exp_wr = 0;
  endtask
`endif

  task automatic test_random();
    logic       mw;
    logic [7:0] a;
    for (int i = 0; i < 40; i++) begin
      mw = 1'($urandom);
      a  = 8'($urandom_range(0, 63));
      access_a(mw, a, 8'($urandom));
    end
  endtask

  // Zero wait states: single-cycle accesses, ready every other cycle with req held.
  task automatic test_zero_wait();
    logic [7:0] wa [0:1];
    logic [7:0] wd [0:1];
    wa[0] = 8'h00; wd[0] = 8'h11;
    wa[1] = 8'hFF; wd[1] = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_b = 1'b1; mw_b = 1'b1; addr_b = wa[i]; din_b = wd[i];
      @(negedge clk);
      req_b = 1'b0;
      n_vec++;
      if (ready_b !== 1'b1 || busy_b !== 1'b1) begin
        n_err++; $display("FAIL zw_write%0d: got ready=%b busy=%b, want 1 1", i, ready_b, busy_b);
      end
    end
    @(negedge clk);
    req_b = 1'b1; mw_b = 1'b0; addr_b = 8'h00;
    @(negedge clk);
    n_vec++;
    if (ready_b !== 1'b1 || dout_b !== 8'h11) begin
      n_err++; $display("FAIL zw_rd0: got ready=%b dout=%02h, want 1 11", ready_b, dout_b);
    end
    addr_b = 8'hFF;
    @(negedge clk);
    n_vec++;
    if (ready_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 8'h11) begin
      n_err++; $display("FAIL zw_gap: got ready=%b busy=%b dout=%02h, want 0 0 11", ready_b, busy_b, dout_b);
    end
    @(negedge clk);
    req_b = 1'b0;
    n_vec++;
    if (ready_b !== 1'b1 || dout_b !== 8'hEE) begin
      n_err++; $display("FAIL zw_rd1: got ready=%b dout=%02h, want 1 ee", ready_b, dout_b);
    end
    @(negedge clk);
    n_vec++;
    if (ready_b !== 1'b0 || busy_b !== 1'b0) begin
      n_err++; $display("FAIL zw_end: got ready=%b busy=%b, want 0 0", ready_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dout_hold();
    test_req_hold();
    test_reset_mid();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    test_random();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
